// File: rtl/ft600_pkg.sv
// Shared definitions for the FT600 245-mode bus scheduler.
//   ft_state_e     : 3-bit scheduler state encoding
//   DefMaxBurst    : default words per grant before forced re-arbitration
//   DefTurnaround  : default idle cycles after each grant
//   DefCntW        : default burst counter width
package ft600_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRdOe   = 3'd1,
    StRdData = 3'd2,
    StWrData = 3'd3,
    StTurn   = 3'd4
  } ft_state_e;

  localparam int unsigned DefMaxBurst   = 256;
  localparam int unsigned DefTurnaround = 1;
  localparam int unsigned DefCntW       = 9;

endpackage

// File: rtl/ft600_bus_scheduler.sv
// FT600 245-mode half-duplex bus scheduler (ft_clk domain).
// Arbitrates between FT600->RX FIFO reads and TX FIFO->FT600 writes with
// round-robin fairness, a per-grant burst limit and a post-grant idle gap.
//   ft_clk, rst          : clock, synchronous active-high reset
//   ft_rxf_n, ft_txe_n   : FT600 status (active low)
//   rx_fifo_full         : RX FIFO cannot accept a word
//   tx_fifo_empty        : TX FIFO has no show-ahead head word
//   ft_oe_n/rd_n/wr_n    : FT600 strobes (active low)
//   drive_en             : pads drive TX FIFO head onto the bus
//   rx_push, tx_pop      : one FIFO op per word actually transferred
//   grant_rx, busy       : last grant direction, scheduler not idle
//   burst_cnt            : words moved in the current grant
module ft600_bus_scheduler
  import ft600_pkg::*;
#(
  parameter int unsigned MAX_BURST  = DefMaxBurst,
  parameter int unsigned TURNAROUND = DefTurnaround,
  parameter int unsigned CNT_W      = DefCntW
) (
  input  logic             ft_clk,
  input  logic             rst,
  input  logic             ft_rxf_n,
  input  logic             ft_txe_n,
  input  logic             rx_fifo_full,
  input  logic             tx_fifo_empty,
  output logic             ft_oe_n,
  output logic             ft_rd_n,
  output logic             ft_wr_n,
  output logic             drive_en,
  output logic             rx_push,
  output logic             tx_pop,
  output logic             grant_rx,
  output logic             busy,
  output logic [CNT_W-1:0] burst_cnt
);

  localparam logic [CNT_W-1:0] MaxCnt  = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(MAX_BURST - 1);
  // TURN always lasts at least one cycle, even with TURNAROUND = 0.
  localparam logic [2:0] TurnLast = (TURNAROUND == 0) ? 3'd0 : 3'(TURNAROUND - 1);

  ft_state_e        state_q, state_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [2:0]       turn_cnt_q, turn_cnt_d;
  logic             grant_rx_q, grant_rx_d;
  logic             rx_req, tx_req, below_max;

  assign rx_req    = ~ft_rxf_n & ~rx_fifo_full;
  assign tx_req    = ~ft_txe_n & ~tx_fifo_empty;
  assign below_max = burst_cnt_q < MaxCnt;

  always_ff @(posedge ft_clk) begin
    if (rst) begin
      state_q     <= StIdle;
      burst_cnt_q <= '0;
      turn_cnt_q  <= '0;
      grant_rx_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      turn_cnt_q  <= turn_cnt_d;
      grant_rx_q  <= grant_rx_d;
    end
  end

  // Strobes are combinational so backpressure and reset take effect in the same cycle.
  always_comb begin
    ft_oe_n  = 1'b1;
    ft_rd_n  = 1'b1;
    ft_wr_n  = 1'b1;
    drive_en = 1'b0;
    if (!rst) begin
      ft_oe_n  = !(state_q == StRdOe || state_q == StRdData);
      ft_rd_n  = !(state_q == StRdData && !rx_fifo_full && below_max);
      ft_wr_n  = !(state_q == StWrData && !tx_fifo_empty && below_max);
      drive_en = (state_q == StWrData);
    end
    rx_push = ~ft_rd_n & ~ft_rxf_n;
    tx_pop  = ~ft_wr_n & ~ft_txe_n;
  end

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    turn_cnt_d  = turn_cnt_q;
    grant_rx_d  = grant_rx_q;
    unique case (state_q)
      StIdle: begin
        // On contention serve the direction that did not hold the last grant.
        if (rx_req && (!tx_req || !grant_rx_q)) begin
          state_d     = StRdOe;
          grant_rx_d  = 1'b1;
          burst_cnt_d = '0;
        end else if (tx_req) begin
          state_d     = StWrData;
          grant_rx_d  = 1'b0;
          burst_cnt_d = '0;
        end
      end
      StRdOe: state_d = StRdData;
      StRdData: begin
        if (rx_push) burst_cnt_d = burst_cnt_q + 1'b1;
        if (ft_rxf_n || rx_fifo_full || (rx_push && burst_cnt_q == LastCnt)) begin
          state_d    = StTurn;
          turn_cnt_d = '0;
        end
      end
      StWrData: begin
        if (tx_pop) burst_cnt_d = burst_cnt_q + 1'b1;
        if (ft_txe_n || tx_fifo_empty || (tx_pop && burst_cnt_q == LastCnt)) begin
          state_d    = StTurn;
          turn_cnt_d = '0;
        end
      end
      StTurn: begin
        if (turn_cnt_q == TurnLast) state_d = StIdle;
        else turn_cnt_d = turn_cnt_q + 3'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  assign grant_rx  = grant_rx_q;
  assign busy      = (state_q != StIdle);
  assign burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_ft600_bus_scheduler.sv
// Self-checking bench for ft600_bus_scheduler: directed scenarios followed by
// randomized traffic, every cycle compared against a behavioural model.
module tb_ft600_bus_scheduler;

  localparam int MB = 6;
  localparam int TA = 2;
  localparam int CW = 9;

  localparam int PhIdle = 0;
  localparam int PhOe   = 1;
  localparam int PhRd   = 2;
  localparam int PhWr   = 3;
  localparam int PhTurn = 4;

  logic          ft_clk = 1'b0;
  logic          rst, ft_rxf_n, ft_txe_n, rx_fifo_full, tx_fifo_empty;
  logic          ft_oe_n, ft_rd_n, ft_wr_n, drive_en, rx_push, tx_pop, grant_rx, busy;
  logic [CW-1:0] burst_cnt;

  ft600_bus_scheduler #(
    .MAX_BURST (MB),
    .TURNAROUND(TA),
    .CNT_W     (CW)
  ) dut (
    .ft_clk       (ft_clk),
    .rst          (rst),
    .ft_rxf_n     (ft_rxf_n),
    .ft_txe_n     (ft_txe_n),
    .rx_fifo_full (rx_fifo_full),
    .tx_fifo_empty(tx_fifo_empty),
    .ft_oe_n      (ft_oe_n),
    .ft_rd_n      (ft_rd_n),
    .ft_wr_n      (ft_wr_n),
    .drive_en     (drive_en),
    .rx_push      (rx_push),
    .tx_pop       (tx_pop),
    .grant_rx     (grant_rx),
    .busy         (busy),
    .burst_cnt    (burst_cnt)
  );

  always #5 ft_clk = ~ft_clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Environment: words waiting in the FT600, free RX FIFO slots, TX FIFO words.
  int rx_src = 0;
  int rx_room = 1000;
  int tx_lvl = 0;
  bit ft_ready = 1'b1;
  int n_push = 0;
  int n_pop = 0;

  // Behavioural model of the scheduler.
  int m_ph = PhIdle;
  int m_cnt = 0;
  int m_turn = 0;
  bit m_grant = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s at %0t: observed %0h required %0h", tag, $time, obs, exp);
    end
  endtask

  // One bus cycle: apply inputs after the falling edge, check outputs, advance at rising edge.
  task automatic cycle(input bit txe_hi, input bit rst_v);
    bit e_oe, e_rd, e_wr, e_drv, e_push, e_pop, rxr, txr;
    rst           = rst_v;
    ft_rxf_n      = (rx_src == 0);
    ft_txe_n      = txe_hi | !ft_ready;
    rx_fifo_full  = (rx_room == 0);
    tx_fifo_empty = (tx_lvl == 0);

    e_oe   = rst_v | !(m_ph == PhOe || m_ph == PhRd);
    e_rd   = rst_v | !(m_ph == PhRd && !rx_fifo_full && m_cnt < MB);
    e_wr   = rst_v | !(m_ph == PhWr && !tx_fifo_empty && m_cnt < MB);
    e_drv  = !rst_v && (m_ph == PhWr);
    e_push = !e_rd && !ft_rxf_n;
    e_pop  = !e_wr && !ft_txe_n;
    #1;
    chk("ft_oe_n", 32'(ft_oe_n), 32'(e_oe));
    chk("ft_rd_n", 32'(ft_rd_n), 32'(e_rd));
    chk("ft_wr_n", 32'(ft_wr_n), 32'(e_wr));
    chk("drive_en", 32'(drive_en), 32'(e_drv));
    chk("rx_push", 32'(rx_push), 32'(e_push));
    chk("tx_pop", 32'(tx_pop), 32'(e_pop));
    chk("grant_rx", 32'(grant_rx), 32'(m_grant));
    chk("busy", 32'(busy), 32'(m_ph != PhIdle));
    chk("burst_cnt", 32'(burst_cnt), 32'(m_cnt));

    // Model next state from the rules for this cycle's inputs.
    rxr = !ft_rxf_n && !rx_fifo_full;
    txr = !ft_txe_n && !tx_fifo_empty;
    if (rst_v) begin
      m_ph = PhIdle; m_cnt = 0; m_turn = 0; m_grant = 1'b0;
    end else begin
      case (m_ph)
        PhIdle: begin
          if (rxr && (!txr || !m_grant)) begin
            m_ph = PhOe; m_grant = 1'b1; m_cnt = 0;
          end else if (txr) begin
            m_ph = PhWr; m_grant = 1'b0; m_cnt = 0;
          end
        end
        PhOe: m_ph = PhRd;
        PhRd: begin
          if (ft_rxf_n || rx_fifo_full || (e_push && m_cnt == MB - 1)) begin
            m_ph = PhTurn; m_turn = (TA > 1) ? TA : 1;
          end
          if (e_push) m_cnt++;
        end
        PhWr: begin
          if (ft_txe_n || tx_fifo_empty || (e_pop && m_cnt == MB - 1)) begin
            m_ph = PhTurn; m_turn = (TA > 1) ? TA : 1;
          end
          if (e_pop) m_cnt++;
        end
        default: begin
          m_turn--;
          if (m_turn == 0) m_ph = PhIdle;
        end
      endcase
    end

    // Environment follows what the DUT actually did.
    if (rx_push === 1'b1) begin
      n_push++;
      if (rx_src > 0) rx_src--;
      if (rx_room > 0) rx_room--;
    end
    if (tx_pop === 1'b1) begin
      n_pop++;
      if (tx_lvl > 0) tx_lvl--;
    end
    @(posedge ft_clk);
    @(negedge ft_clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
  endtask

  initial begin
    int p0, q0;
    rst = 1'b1; ft_rxf_n = 1'b1; ft_txe_n = 1'b1; rx_fifo_full = 1'b0; tx_fifo_empty = 1'b1;
    @(posedge ft_clk);
    @(negedge ft_clk);
    // Reset state, held in reset.
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    idle_cycles(2);

    // RX only: 5 words, OE leads RD by one cycle, then TURN and IDLE.
    p0 = n_push; rx_src = 5; rx_room = 1000;
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0);
    chk("rx_only_words", 32'(n_push - p0), 32'd5);
    chk("rx_only_grant", 32'(grant_rx), 32'd1);
    chk("rx_only_cnt", 32'(burst_cnt), 32'd5);

    // TX only: 3 words, exit on empty.
    q0 = n_pop; tx_lvl = 3;
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0);
    chk("tx_only_words", 32'(n_pop - q0), 32'd3);
    chk("tx_only_cnt", 32'(burst_cnt), 32'd3);
    chk("tx_only_grant", 32'(grant_rx), 32'd0);

    // Contention: RX(10 cycles) TX(9) RX(10) TX(9), each grant capped at MB words.
    p0 = n_push; q0 = n_pop; rx_src = 100; tx_lvl = 100;
    for (int i = 0; i < 38; i++) cycle(1'b0, 1'b0);
    chk("cont_rx_words", 32'(n_push - p0), 32'(2 * MB));
    chk("cont_tx_words", 32'(n_pop - q0), 32'(2 * MB));
    chk("cont_busy", 32'(busy), 32'd0);
    rx_src = 0; tx_lvl = 0;
    idle_cycles(2);

    // Backpressure: RX FIFO fills after 2 words.
    p0 = n_push; rx_src = 10; rx_room = 2;
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0);
    chk("bp_words", 32'(n_push - p0), 32'd2);
    rx_src = 0; rx_room = 1000;
    idle_cycles(2);

    // TX stall on the third cycle of the grant; remaining words follow on a later grant.
    q0 = n_pop; tx_lvl = 5;
    for (int i = 1; i <= 14; i++) cycle(i == 4, 1'b0);
    chk("stall_words", 32'(n_pop - q0), 32'd5);
    chk("stall_left", 32'(tx_lvl), 32'd0);

    // Reset during the second word of a TX grant.
    q0 = n_pop; tx_lvl = 5;
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    chk("rst_words", 32'(n_pop - q0), 32'd1);
    cycle(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0);
    chk("rst_rest", 32'(n_pop - q0), 32'd5);
    idle_cycles(2);

    // Randomized traffic with occasional reset.
    rx_room = 3;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 2) == 0 && rx_src < 20) rx_src++;
      if ($urandom_range(0, 3) == 0 && rx_room < 6) rx_room++;
      if ($urandom_range(0, 2) == 0 && tx_lvl < 20) tx_lvl++;
      ft_ready = ($urandom_range(0, 5) != 0);
      cycle(1'b0, $urandom_range(0, 149) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/ft600_bus_scheduler.md
Name: ft600_bus_scheduler

Overview:
- Owns the FT600 245-mode half-duplex bus in the ft_clk domain.
- Decides each cycle whether the bus reads (FT600 to RX FIFO) or writes (TX FIFO to FT600).
- Generates the ft_oe_n/ft_rd_n/ft_wr_n strobes and the FIFO push/pop enables.
- Enforces direction fairness, a per-grant burst limit and bus-turnaround gaps, so one direction cannot starve the other.
- Sits between the async RX/TX FIFOs and the pad tristate logic.

Parameters:
MAX_BURST, 256, max words transferred per grant before forced re-arbitration (1..2^CNT_W-1)
TURNAROUND, 1, idle cycles inserted after every grant before the next arbitration (0..7)
CNT_W, 9, burst counter width; must hold MAX_BURST

Ports:
ft_clk  in  1  FT600 clock; all logic on posedge
rst  in  1  synchronous, active-high reset
ft_rxf_n  in  1  FT600 has RX data (active low)
ft_txe_n  in  1  FT600 can accept TX data (active low)
rx_fifo_full  in  1  RX FIFO write-side full
tx_fifo_empty  in  1  TX FIFO read-side empty (show-ahead head word valid when 0)
ft_oe_n  out  1  FT600 output enable (active low)
ft_rd_n  out  1  FT600 read strobe (active low)
ft_wr_n  out  1  FT600 write strobe (active low)
drive_en  out  1  pads drive ft_data/ft_be from TX FIFO head
rx_push  out  1  write ft_data into RX FIFO this cycle
tx_pop  out  1  advance TX FIFO head this cycle
grant_rx  out  1  current or most recent grant was RX
busy  out  1  state != IDLE
burst_cnt  out  CNT_W  words moved in current grant

Behaviour:
- State register (posedge ft_clk): IDLE, RD_OE, RD_DATA, WR_DATA, TURN. Reset: IDLE, burst_cnt=0, turn_cnt=0, grant_rx=0 (so first contention favours RX).
- Strobes are combinational from registered state and inputs. All are forced inactive while rst=1.
  - ft_oe_n = 0 iff state is RD_OE or RD_DATA.
  - ft_rd_n = 0 iff state==RD_DATA & ~rx_fifo_full & burst_cnt<MAX_BURST.
  - ft_wr_n = 0 iff state==WR_DATA & ~tx_fifo_empty & burst_cnt<MAX_BURST.
  - drive_en = (state==WR_DATA).
  - rx_push = ~ft_rd_n & ~ft_rxf_n.
  - tx_pop = ~ft_wr_n & ~ft_txe_n.
  - Result: exactly one FIFO op per word actually transferred.
- rx_req = ~ft_rxf_n & ~rx_fifo_full; tx_req = ~ft_txe_n & ~tx_fifo_empty.
- Arbitration in IDLE:
  - Only rx_req: go to RD_OE, set grant_rx=1.
  - Only tx_req: go to WR_DATA, set grant_rx=0.
  - Both: grant the direction opposite grant_rx (round-robin).
  - Neither: stay in IDLE.
  - burst_cnt cleared on every grant.
- RD_OE: exactly 1 cycle (OE-before-RD turnaround), then RD_DATA.
- RD_DATA:
  - burst_cnt increments on each rx_push.
  - Go to TURN at the edge where any of: ft_rxf_n=1, rx_fifo_full=1, or (rx_push & burst_cnt==MAX_BURST-1).
- WR_DATA:
  - burst_cnt increments on each tx_pop.
  - Go to TURN when any of: ft_txe_n=1, tx_fifo_empty=1, or (tx_pop & burst_cnt==MAX_BURST-1).
  - A stalled cycle (ft_txe_n=1 with ft_wr_n=0) pops nothing.
- TURN: all strobes inactive; hold TURNAROUND cycles, then IDLE. With TURNAROUND=0, TURN lasts 1 cycle minimum. Every grant therefore ends with ≥1 fully idle bus cycle.
- Latency: request seen in IDLE → first RX word pushed 2 cycles later (RD_OE, then RD_DATA); first TX word popped 1 cycle later.
- burst_cnt saturates at MAX_BURST and never wraps.
- Reset mid-grant: strobes drop in the same cycle rst rises; state is IDLE after the edge. No partial-word push or pop occurs.
- Simultaneous exit conditions: any single one suffices; TURN is always the destination. Never go directly RD_DATA↔WR_DATA.

Decomposition:
- Shared package ft600_pkg: state encoding constants (3-bit), default MAX_BURST/TURNAROUND.
- No sub-module; the arbiter is small. Optional turnaround counter inline.

Test Plan:
- RX only: ft_rxf_n low for 5 words, RX FIFO empty → ft_oe_n low 1 cycle before ft_rd_n; rx_push pulses 5 times; then TURN 1 cycle, IDLE; grant_rx=1.
- TX only: TX FIFO holds 3 words, ft_txe_n low → drive_en and ft_wr_n low 3 cycles, tx_pop ×3; exit on tx_fifo_empty; burst_cnt=3.
- Contention, MAX_BURST=4: both requests held continuously → grants alternate RX,TX,RX,…; each grant moves exactly 4 words, separated by TURNAROUND idle cycles.
- Backpressure: rx_fifo_full rises after word 2 of an RX grant → ft_rd_n deasserts in the same cycle; no push; TURN next.
- TX stall: ft_txe_n high for 1 cycle mid-burst → tx_pop=0 that cycle; state goes TURN; remaining words are sent on the next TX grant with none lost or duplicated.
- Reset mid-burst: rst pulse during WR_DATA word 2 → ft_wr_n/drive_en high immediately, tx_pop=0; IDLE and burst_cnt=0 after the edge.
